stfq_push_driver: RTL and testbench

- Enqueue-side initiator for the two-lane PIFO flow scheduler.
- Accepts packet arrivals tagged with a flow id and length, and buffers them in a small FIFO.
- Computes start-time-fair-queuing (STFQ) ranks per flow and drives the scheduler's push_1/push_2 lanes.
- Keeps a credit count of scheduler occupancy, so the scheduler is never pushed past capacity despite its 2-cycle internal pipeline.

---
 rtl/stfq_push_driver.sv | 142 ++++++++++++++
 tb/tb_stfq_push_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stfq_push_driver.sv
// Enqueue-side initiator for the two-lane PIFO scheduler: buffers arrivals,
// assigns STFQ ranks per flow and pushes up to two entries per cycle within credit.
module stfq_push_driver #(
  parameter int unsigned NUM_FLOWS   = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SCHED_DEPTH = 10,
  localparam int unsigned FW = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1,
  localparam int unsigned CW = $clog2(SCHED_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arr_valid,
  output logic          arr_ready,
  input  logic [FW-1:0] arr_flow,
  input  logic [31:0]   arr_len,
  input  logic [31:0]   arr_value,
  input  logic          cfg_we,
  input  logic [FW-1:0] cfg_flow,
  input  logic [3:0]    cfg_shift,
  input  logic          deq_valid,
  input  logic [31:0]   deq_rank,
  input  logic          sched_full,
  output logic          push_1,
  output logic [31:0]   push_rank_1,
  output logic [31:0]   push_value_1,
  output logic          push_2,
  output logic [31:0]   push_rank_2,
  output logic [31:0]   push_value_2,
  output logic [CW-1:0] credits
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [FW-1:0] flow;
    logic [31:0]   len;
    logic [31:0]   value;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]   vtime;
  logic [31:0]   finish [NUM_FLOWS];
  logic [3:0]    shift  [NUM_FLOWS];

  logic             accept;
  logic [1:0]       n;
  logic [CW-1:0]    avail;
  logic [CW-1:0]    credits_next;
  logic [CNT_W-1:0] count_next;
  entry_t           head1, head2;
  logic [31:0]      start1, fin1, prev2, start2, fin2;

  // Cost of len << shift, saturating when any bit would be shifted out.
  function automatic logic [31:0] cost_f(input logic [31:0] len, input logic [3:0] sh);
    logic [46:0] w;
    w = {15'd0, len} << sh;
    return (|w[46:32]) ? 32'hFFFF_FFFF : w[31:0];
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Issue decision and rank math from registered state only.
  always_comb begin
    accept = arr_valid && arr_ready;
    avail  = CW'(SCHED_DEPTH) - credits;
    n      = 2'd0;
    if (!sched_full) begin
      n = (count < CNT_W'(2)) ? 2'(count) : 2'd2;
      if (avail < CW'(n)) n = 2'(avail);
    end

    head1  = mem[rd_ptr];
    head2  = mem[rd_ptr + AW'(1)];
    start1 = max32(vtime, finish[head1.flow]);
    fin1   = sat_add(start1, cost_f(head1.len, shift[head1.flow]));
    // Lane 2 chains on lane 1's finish when both carry the same flow.
    prev2  = (head2.flow == head1.flow) ? fin1 : finish[head2.flow];
    start2 = max32(vtime, prev2);
    fin2   = sat_add(start2, cost_f(head2.len, shift[head2.flow]));

    count_next   = count + CNT_W'(accept) - CNT_W'(n);
    credits_next = credits + CW'(n) - CW'(deq_valid && (credits != '0));
  end

  // Arrival storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= '{flow: arr_flow, len: arr_len, value: arr_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      arr_ready    <= 1'b1;
      push_1       <= 1'b0;
      push_rank_1  <= '0;
      push_value_1 <= '0;
      push_2       <= 1'b0;
      push_rank_2  <= '0;
      push_value_2 <= '0;
      vtime        <= '0;
      credits      <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        finish[i] <= '0;
        shift[i]  <= '0;
      end
    end else begin
      count     <= count_next;
      arr_ready <= (count_next < CNT_W'(FIFO_DEPTH));
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr + AW'(n);
      credits   <= credits_next;

      push_1       <= (n != 2'd0);
      push_rank_1  <= (n != 2'd0) ? start1 : '0;
      push_value_1 <= (n != 2'd0) ? head1.value : '0;
      push_2       <= (n == 2'd2);
      push_rank_2  <= (n == 2'd2) ? start2 : '0;
      push_value_2 <= (n == 2'd2) ? head2.value : '0;

      // Lane 2 write comes last so a shared flow keeps the chained finish.
      if (n != 2'd0) finish[head1.flow] <= fin1;
      if (n == 2'd2) finish[head2.flow] <= fin2;

      if (cfg_we) shift[cfg_flow] <= cfg_shift;
      if (deq_valid && (deq_rank > vtime)) vtime <= deq_rank;
    end
  end

endmodule

// File: tb/tb_stfq_push_driver.sv
// Directed bench for stfq_push_driver: ranks, chaining, credits, saturation, reset.
module tb_stfq_push_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arr_valid;
  logic        arr_ready;
  logic [1:0]  arr_flow;
  logic [31:0] arr_len;
  logic [31:0] arr_value;
  logic        cfg_we;
  logic [1:0]  cfg_flow;
  logic [3:0]  cfg_shift;
  logic        deq_valid;
  logic [31:0] deq_rank;
  logic        sched_full;
  logic        push_1, push_2;
  logic [31:0] push_rank_1, push_value_1, push_rank_2, push_value_2;
  logic [3:0]  credits;

  int n_checks = 0;
  int n_fail   = 0;

  stfq_push_driver dut (
    .clk(clk), .rst_n(rst_n),
    .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_flow(arr_flow),
    .arr_len(arr_len), .arr_value(arr_value),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_shift(cfg_shift),
    .deq_valid(deq_valid), .deq_rank(deq_rank), .sched_full(sched_full),
    .push_1(push_1), .push_rank_1(push_rank_1), .push_value_1(push_value_1),
    .push_2(push_2), .push_rank_2(push_rank_2), .push_value_2(push_value_2),
    .credits(credits)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] f, input logic [31:0] len, input logic [31:0] val);
    arr_valid = 1'b1;
    arr_flow  = f;
    arr_len   = len;
    arr_value = val;
  endtask

  // Two arrivals held back by sched_full so they issue together.
  task automatic pair(input logic [1:0] f1, input logic [31:0] l1, input logic [31:0] v1,
                      input logic [1:0] f2, input logic [31:0] l2, input logic [31:0] v2);
    sched_full = 1'b1;
    offer(f1, l1, v1);
    step();
    offer(f2, l2, v2);
    step();
    arr_valid  = 1'b0;
    sched_full = 1'b0;
    step();
  endtask

  initial begin
    int acc;
    int pushes;
    logic ready_s;

    rst_n = 1'b0; arr_valid = 1'b0; arr_flow = '0; arr_len = '0; arr_value = '0;
    cfg_we = 1'b0; cfg_flow = '0; cfg_shift = '0; deq_valid = 1'b0; deq_rank = '0;
    sched_full = 1'b0;
    step();
    step();
    chk("rst_push_1", 32'(push_1), 32'd0);
    chk("rst_arr_ready", 32'(arr_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_push", 32'(push_1 | push_2), 32'd0);
      chk("idle_ready", 32'(arr_ready), 32'd1);
      chk("idle_credits", 32'(credits), 32'd0);
    end

    // Single arrival: visible two cycles after acceptance.
    offer(2'd0, 32'd100, 32'hA1);
    step();
    arr_valid = 1'b0;
    chk("single_early", 32'(push_1), 32'd0);
    step();
    chk("single_push_1", 32'(push_1), 32'd1);
    chk("single_rank", push_rank_1, 32'd0);
    chk("single_value", push_value_1, 32'hA1);
    chk("single_push_2", 32'(push_2), 32'd0);
    chk("single_credits", 32'(credits), 32'd1);
    step();
    chk("single_pulse", 32'(push_1), 32'd0);

    // Two flow-0 arrivals issued together; finish[0]=100 from before.
    pair(2'd0, 32'd100, 32'hB1, 2'd0, 32'd100, 32'hB2);
    chk("pair_push_1", 32'(push_1), 32'd1);
    chk("pair_rank_1", push_rank_1, 32'd100);
    chk("pair_value_1", push_value_1, 32'hB1);
    chk("pair_push_2", 32'(push_2), 32'd1);
    chk("pair_rank_2", push_rank_2, 32'd200);
    chk("pair_value_2", push_value_2, 32'hB2);
    chk("pair_credits", 32'(credits), 32'd3);

    // Flow 1 weight shift 2, vtime raised to 50 by a dequeue.
    cfg_we = 1'b1; cfg_flow = 2'd1; cfg_shift = 4'd2;
    step();
    cfg_we = 1'b0;
    deq_valid = 1'b1; deq_rank = 32'd50;
    step();
    deq_valid = 1'b0;
    chk("deq_credits", 32'(credits), 32'd2);
    offer(2'd1, 32'd10, 32'hC1);
    step();
    arr_valid = 1'b0;
    step();
    chk("vt_rank", push_rank_1, 32'd50);
    chk("vt_credits", 32'(credits), 32'd3);
    deq_valid = 1'b1; deq_rank = 32'd30;
    step();
    deq_valid = 1'b0;
    // vtime must stay 50; finish[1] = 50 + (10<<2) = 90.
    pair(2'd2, 32'd5, 32'hE1, 2'd1, 32'd10, 32'hE2);
    chk("mono_rank_1", push_rank_1, 32'd50);
    chk("mono_rank_2", push_rank_2, 32'd90);
    chk("mono_credits", 32'(credits), 32'd4);

    // Saturating cost: 0x20000 << 15 overflows 32 bits.
    cfg_we = 1'b1; cfg_flow = 2'd3; cfg_shift = 4'd15;
    step();
    cfg_we = 1'b0;
    pair(2'd3, 32'h0002_0000, 32'hD1, 2'd3, 32'd1, 32'hD2);
    chk("sat_rank_1", push_rank_1, 32'd50);
    chk("sat_rank_2", push_rank_2, 32'hFFFF_FFFF);
    chk("sat_credits", 32'(credits), 32'd6);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_credits", 32'(credits), 32'd0);

    // Fill scheduler to capacity with 12 flow-0 arrivals, no dequeues.
    acc = 0;
    pushes = 0;
    for (int c = 0; c < 40; c++) begin
      if (acc < 12) offer(2'd0, 32'd1, 32'h100 + 32'(acc));
      else arr_valid = 1'b0;
      ready_s = arr_ready;
      step();
      if (arr_valid && ready_s) acc++;
      if (push_1) begin
        chk("fill_value", push_value_1, 32'h100 + 32'(pushes));
        chk("fill_rank", push_rank_1, 32'(pushes));
        pushes++;
      end
      if (push_2) pushes++;
    end
    arr_valid = 1'b0;
    chk("fill_pushes", 32'(pushes), 32'd10);
    chk("fill_credits", 32'(credits), 32'd10);
    chk("fill_ready_2held", 32'(arr_ready), 32'd1);

    for (int c = 0; c < 10; c++) begin
      if (acc < 14) offer(2'd0, 32'd1, 32'h100 + 32'(acc));
      else arr_valid = 1'b0;
      ready_s = arr_ready;
      step();
      if (arr_valid && ready_s) acc++;
      if (push_1 || push_2) pushes++;
    end
    arr_valid = 1'b0;
    chk("full_ready", 32'(arr_ready), 32'd0);
    chk("full_nopush", 32'(pushes), 32'd10);
    offer(2'd0, 32'd1, 32'hBAD);
    step();
    arr_valid = 1'b0;
    chk("full_reject_ready", 32'(arr_ready), 32'd0);

    // One dequeue releases exactly one push.
    deq_valid = 1'b1; deq_rank = 32'd0;
    step();
    deq_valid = 1'b0;
    chk("rel_credits_dip", 32'(credits), 32'd9);
    chk("rel_wait", 32'(push_1), 32'd0);
    step();
    chk("rel_push", 32'(push_1), 32'd1);
    chk("rel_value", push_value_1, 32'h10A);
    chk("rel_rank", push_rank_1, 32'd10);
    chk("rel_credits", 32'(credits), 32'd10);
    chk("rel_ready", 32'(arr_ready), 32'd1);
    pushes = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (push_1 || push_2) pushes++;
    end
    chk("rel_only_one", 32'(pushes), 32'd0);

    // Reset lands while a push pulse is on the outputs.
    deq_valid = 1'b1;
    step();
    deq_valid = 1'b0;
    step();
    chk("inflight_push", 32'(push_1), 32'd1);
    chk("inflight_rank", push_rank_1, 32'd11);
    rst_n = 1'b0;
    #1;
    chk("async_push_1", 32'(push_1), 32'd0);
    chk("async_rank_1", push_rank_1, 32'd0);
    chk("async_value_1", push_value_1, 32'd0);
    chk("async_credits", 32'(credits), 32'd0);
    chk("async_ready", 32'(arr_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    deq_valid = 1'b1;
    step();
    deq_valid = 1'b0;
    chk("deq_at_zero", 32'(credits), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("post_rst_push", 32'(push_1 | push_2), 32'd0);
      chk("post_rst_credits", 32'(credits), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
